// File: rtl/cga_pkg.sv
// Shared constants for the CGA CRTC register block: decoded I/O ports,
// implemented CRTC register indices and the status byte layout.
package cga_pkg;

  localparam logic [15:0] CRTC_INDEX = 16'h03D4;
  localparam logic [15:0] CRTC_DATA  = 16'h03D5;
  localparam logic [15:0] CGA_STATUS = 16'h03DA;

  localparam logic [4:0] R_CUR_START = 5'h0A;
  localparam logic [4:0] R_CUR_END   = 5'h0B;
  localparam logic [4:0] R_CUR_HI    = 5'h0E;
  localparam logic [4:0] R_CUR_LO    = 5'h0F;

  // Status port: bit 3 = vertical retrace, bit 0 = not in the visible window.
  function automatic logic [7:0] status_byte(input logic vs_i, input logic de_i);
    return {4'b0000, vs_i, 2'b00, ~de_i};
  endfunction

endpackage

// File: rtl/cga_blink.sv
// Frame-rate blink generator: counts vs rising edges and derives the cursor
// and character blink phases from a shared 5-bit frame counter.
module cga_blink
  import cga_pkg::*;
#(
  parameter int CURSOR_BLINK_FRAMES = 16,
  parameter int CHAR_BLINK_FRAMES   = 32
) (
  input  logic clock_25,
  input  logic reset_n,
  input  logic vs,
  output logic cursor_phase,
  output logic char_blink
);

  logic       vs_q,     vs_d;
  logic       armed_q,  armed_d;
  logic [4:0] cnt_q,    cnt_d;
  logic       phase_q,  phase_d;
  logic       cblink_q, cblink_d;
  logic       tick_s;
  logic       cur_wrap_s;
  logic       chr_wrap_s;

  // armed_q stays low until vs is seen low, so vs held high through reset is not a tick.
  assign tick_s     = vs & ~vs_q & armed_q;
  assign cur_wrap_s = (int'(cnt_q) % CURSOR_BLINK_FRAMES) == (CURSOR_BLINK_FRAMES - 1);
  assign chr_wrap_s = (int'(cnt_q) % CHAR_BLINK_FRAMES) == (CHAR_BLINK_FRAMES - 1);

  always_comb begin
    vs_d     = vs;
    armed_d  = armed_q | ~vs;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    cblink_d = cblink_q;
    if (tick_s) begin
      cnt_d    = cnt_q + 5'd1;
      phase_d  = cur_wrap_s ? ~phase_q : phase_q;
      cblink_d = chr_wrap_s ? ~cblink_q : cblink_q;
    end else begin
      cnt_d    = cnt_q;
    end
  end

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      vs_q     <= 1'b0;
      armed_q  <= 1'b0;
      cnt_q    <= 5'd0;
      phase_q  <= 1'b1;
      cblink_q <= 1'b0;
    end else begin
      vs_q     <= vs_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      cblink_q <= cblink_d;
    end
  end

  assign cursor_phase = phase_q;
  assign char_blink   = cblink_q;

endmodule

// File: rtl/cga_crtc.sv
// CPU-facing CRTC register block: decodes 0x3D4/0x3D5/0x3DA, holds the index
// and cursor registers, and drives cursor position/shape/blink to scan-out.
module cga_crtc
  import cga_pkg::*;
#(
  parameter int CURSOR_BLINK_FRAMES = 16,
  parameter int CHAR_BLINK_FRAMES   = 32
) (
  input  logic        clock_25,
  input  logic        reset_n,
  input  logic [15:0] port_addr,
  input  logic        port_we,
  input  logic        port_rd,
  input  logic [7:0]  port_wdata,
  output logic [7:0]  port_rdata,
  input  logic        vs,
  input  logic        de,
  output logic [10:0] cursor,
  output logic [4:0]  cursor_start,
  output logic [4:0]  cursor_end,
  output logic        cursor_on,
  output logic        char_blink
);

  logic [4:0] idx_q,   idx_d;
  logic [5:0] r0a_q,   r0a_d;
  logic [4:0] r0b_q,   r0b_d;
  logic [5:0] r0e_q,   r0e_d;
  logic [7:0] r0f_q,   r0f_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] reg_rd_s;
  logic       sel_idx_s, sel_dat_s, sel_sts_s;
  logic       cursor_phase_s;

  assign sel_idx_s = (port_addr == CRTC_INDEX);
  assign sel_dat_s = (port_addr == CRTC_DATA);
  assign sel_sts_s = (port_addr == CGA_STATUS);

  always_comb begin
    case (idx_q)
      R_CUR_START: reg_rd_s = {2'b00, r0a_q};
      R_CUR_END:   reg_rd_s = {3'b000, r0b_q};
      R_CUR_HI:    reg_rd_s = {2'b00, r0e_q};
      R_CUR_LO:    reg_rd_s = r0f_q;
      default:     reg_rd_s = 8'h00;
    endcase
  end

  // Reads sample the current registers, so a simultaneous write is seen only afterwards.
  always_comb begin
    idx_d   = idx_q;
    r0a_d   = r0a_q;
    r0b_d   = r0b_q;
    r0e_d   = r0e_q;
    r0f_d   = r0f_q;
    rdata_d = rdata_q;
    if (port_we && sel_idx_s) begin
      idx_d = port_wdata[4:0];
    end else if (port_we && sel_dat_s) begin
      case (idx_q)
        R_CUR_START: r0a_d = port_wdata[5:0];
        R_CUR_END:   r0b_d = port_wdata[4:0];
        R_CUR_HI:    r0e_d = port_wdata[5:0];
        R_CUR_LO:    r0f_d = port_wdata;
        default:     r0f_d = r0f_q;
      endcase
    end else begin
      idx_d = idx_q;
    end
    if (port_rd) begin
      if (sel_idx_s) begin
        rdata_d = {3'b000, idx_q};
      end else if (sel_dat_s) begin
        rdata_d = reg_rd_s;
      end else if (sel_sts_s) begin
        rdata_d = status_byte(vs, de);
      end else begin
        rdata_d = 8'h00;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= 5'h00;
      r0a_q   <= 6'h0E;
      r0b_q   <= 5'h0F;
      r0e_q   <= 6'h00;
      r0f_q   <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      idx_q   <= idx_d;
      r0a_q   <= r0a_d;
      r0b_q   <= r0b_d;
      r0e_q   <= r0e_d;
      r0f_q   <= r0f_d;
      rdata_q <= rdata_d;
    end
  end

  cga_blink #(
    .CURSOR_BLINK_FRAMES(CURSOR_BLINK_FRAMES),
    .CHAR_BLINK_FRAMES  (CHAR_BLINK_FRAMES)
  ) u_blink (
    .clock_25    (clock_25),
    .reset_n     (reset_n),
    .vs          (vs),
    .cursor_phase(cursor_phase_s),
    .char_blink  (char_blink)
  );

  assign port_rdata   = rdata_q;
  assign cursor       = {r0e_q[2:0], r0f_q};
  assign cursor_start = r0a_q[4:0];
  assign cursor_end   = r0b_q;
  assign cursor_on    = cursor_phase_s & ~r0a_q[5];

endmodule
